// File: rtl/mem_image_streamer_pkg.sv
// mem_image_streamer_pkg: state encoding, default load base address and MEM tdata field widths,
// shared by the streamer and the processor-side MEM consumer.
package mem_image_streamer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_WAIT   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_DONE   = 2'd2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0100_0000;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry in-order buffer; the writer guarantees it never pushes into a full buffer.
module axis_skid_buffer #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [1:0] cnt_q, cnt_d, occ;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic pop;
  always_comb begin
    pop = out_valid && out_ready;
    occ = cnt_q - 2'(pop);
    cnt_d = occ + 2'(in_valid);
    e0_d = occ == 2'd0 ? in_data : pop ? e1_q : e0_q;
    e1_d = occ == 2'd1 ? in_data : e1_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 2'd0;
    else cnt_q <= cnt_d;
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end
  assign out_valid = cnt_q != 2'd0;
  assign out_data = e0_q;
  assign count = cnt_q;
endmodule

// File: rtl/mem_image_streamer.sv
// mem_image_streamer: after a start delay, streams line_count image words as {word, byte address}
// AXI-stream beats, holding the processor in reset until the load completes.
module mem_image_streamer
  import mem_image_streamer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int START_DELAY = 100,
  localparam int LC_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LC_W-1:0]          line_count,
  output logic                     rd_en,
  output logic [IDX_W-1:0]         rd_idx,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     MEM_tvalid,
  input  logic                     MEM_tready,
  output logic                     MEM_tlast,
  output logic [DATA_W+ADDR_W-1:0] MEM_tdata,
  output logic                     core_rst,
  output logic                     busy,
  output logic                     done
);
  localparam int CNT_W = $clog2(START_DELAY + 2);
  localparam int P_W = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LC_W-1:0] lc_q, lc_d, lc_in, lc_eff, issued_q, issued_d;
  logic [ADDR_W-1:0] addr_q, addr_d, pend_addr_q, pend_addr_d;
  logic arm_q, arm_d, pend_q, pend_d, pend_last_q, pend_last_d;
  logic issue, pop, sb_valid;
  logic [1:0] sb_cnt;
  logic [P_W-1:0] sb_data;
  // arm_q marks the first WAIT cycle after reset, where line_count is latched
  always_comb begin
    lc_in = line_count > LC_W'(DEPTH) ? LC_W'(DEPTH) : line_count;
    lc_eff = arm_q ? lc_in : lc_q;
    pop = sb_valid && MEM_tready;
    issue = state_q == ST_STREAM && issued_q != lc_q && 3'(sb_cnt) + 3'(pend_q) - 3'(pop) < 3'd2;
    lc_d = state_q == ST_DONE && start ? lc_in : lc_eff;
    arm_d = 1'b0;
    cnt_d = state_q == ST_WAIT ? cnt_q + CNT_W'(1) : '0;
    issued_d = state_q == ST_WAIT ? '0 : issued_q + LC_W'(issue);
    addr_d = state_q == ST_WAIT ? BASE_ADDR : addr_q + (issue ? BYTES : '0);
    pend_d = issue;
    pend_addr_d = addr_q;
    pend_last_d = issued_q == lc_q - LC_W'(1);
    state_d = state_q == ST_WAIT ? (cnt_q == CNT_W'(START_DELAY) ? (lc_eff == '0 ? ST_DONE : ST_STREAM) : ST_WAIT)
            : state_q == ST_STREAM ? (pop && sb_data[0] ? ST_DONE : ST_STREAM)
            : (start ? ST_WAIT : ST_DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cnt_q <= '0;
      lc_q <= '0;
      arm_q <= 1'b1;
      issued_q <= '0;
      addr_q <= BASE_ADDR;
      pend_q <= 1'b0;
      pend_addr_q <= '0;
      pend_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lc_q <= lc_d;
      arm_q <= arm_d;
      issued_q <= issued_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_last_q <= pend_last_d;
    end
  axis_skid_buffer #(.W(P_W)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(pend_q),
    .in_data({rd_data, pend_addr_q, pend_last_q}),
    .out_valid(sb_valid),
    .out_ready(MEM_tready),
    .out_data(sb_data),
    .count(sb_cnt)
  );
  assign rd_en = issue;
  assign rd_idx = issued_q[IDX_W-1:0];
  assign MEM_tvalid = sb_valid;
  assign MEM_tlast = sb_valid && sb_data[0];
  assign MEM_tdata = sb_data[P_W-1:1];
  assign done = state_q == ST_DONE;
  assign busy = !done;
  assign core_rst = !done;
endmodule

// File: tb/tb_mem_image_streamer.sv
// tb_mem_image_streamer: scoreboard-checked load sequences, a vector table over line_count and
// tready duty cycle, mid-stream reset and a 64-bit address-wrap instance.
module tb_mem_image_streamer;
  localparam int SD = 10, DEPTH = 16, DW = 32, AW = 32;
  localparam int LCW = $clog2(DEPTH + 1), IW = $clog2(DEPTH);
  localparam logic [31:0] BASE = 32'h0100_0000;
  typedef logic [DW+AW:0] beat_t;
  typedef struct { int lc; int pct; int exp; int exp_done; } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, tready, rd_en, tvalid, tlast, core_rst, busy, done;
  logic [LCW-1:0] line_count;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
  logic [DW+AW-1:0] tdata;
  logic rst_n_b, start_b, tready_b, rd_en_b, tvalid_b, tlast_b, core_rst_b, busy_b, done_b;
  logic [LCW-1:0] lc_b;
  logic [IW-1:0] rd_idx_b;
  logic [63:0] rd_data_b;
  logic [95:0] tdata_b;

  logic [31:0] mem [DEPTH];
  beat_t sb [$];
  int tests = 0, fails = 0, beats = 0, lasts = 0, pct = 100;
  logic stall = 1'b0;
  beat_t held;

  always #5 clk = ~clk;

  mem_image_streamer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .START_DELAY(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line_count(line_count),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
    .MEM_tvalid(tvalid), .MEM_tready(tready), .MEM_tlast(tlast), .MEM_tdata(tdata),
    .core_rst(core_rst), .busy(busy), .done(done)
  );

  mem_image_streamer #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'hFFFF_FFF8), .START_DELAY(SD)) dut64 (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .line_count(lc_b),
    .rd_en(rd_en_b), .rd_idx(rd_idx_b), .rd_data(rd_data_b),
    .MEM_tvalid(tvalid_b), .MEM_tready(tready_b), .MEM_tlast(tlast_b), .MEM_tdata(tdata_b),
    .core_rst(core_rst_b), .busy(busy_b), .done(done_b)
  );

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_idx];
  always @(posedge clk) if (rd_en_b) rd_data_b <= {mem[rd_idx_b], ~mem[rd_idx_b]};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int n);
    for (int k = 0; k < n; k++) sb.push_back({mem[k], BASE + 32'(k * 4), k == n - 1});
  endtask

  task automatic do_start(input int lc);
    @(negedge clk);
    line_count = LCW'(lc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    line_count = LCW'($urandom);
    chk("start_core_rst", {core_rst, done, busy}, 3'b101);
  endtask

  task automatic run(input int budget, output int dc, output int fr, output int fv);
    dc = -1; fr = -1; fv = -1;
    for (int n = 1; n <= budget && dc < 0; n++) begin
      @(negedge clk);
      if (rd_en && fr < 0) fr = n;
      if (tvalid && fv < 0) fv = n;
      if (done) dc = n;
    end
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 tready = $urandom_range(99) < pct;
    end
  end

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) chk("stall_hold", {tvalid, tdata, tlast}, {1'b1, held});
        if (tvalid && tready) begin
          beats++;
          if (tlast) lasts++;
          if (sb.size() == 0) chk("beat_unexpected", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("beat", {tdata, tlast}, e);
          end
        end
        stall = tvalid && !tready;
        held = {tdata, tlast};
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [8];
    int dc, fr, fv, nb, last_at;
    logic [95:0] got [2];
    v[0] = '{8, 70, 8, -1};
    v[1] = '{2, 100, 2, SD + 5};
    v[2] = '{0, 100, 0, SD + 1};
    v[3] = '{1, 100, 1, SD + 4};
    v[4] = '{20, 60, 16, -1};
    v[5] = '{16, 100, 16, SD + 19};
    v[6] = '{3, 30, 3, -1};
    v[7] = '{5, 50, 5, -1};
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rst_n = 1'b0; start = 1'b0; line_count = 4;
    rst_n_b = 1'b0; start_b = 1'b0; lc_b = 2; tready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, core_rst, tvalid, tlast, rd_en}, 6'b101000);
    push_exp(4);
    rst_n = 1'b1;
    run(SD + 40, dc, fr, fv);
    chk("l4_first_rd", fr, SD + 1);
    chk("l4_first_valid", fv, SD + 3);
    chk("l4_done_at", dc, SD + 7);
    chk("l4_core_rst_low", core_rst, 0);
    chk("l4_beats", beats, 4);
    chk("l4_lasts", lasts, 1);
    chk("l4_sb_empty", sb.size(), 0);

    for (int i = 0; i < 8; i++) begin
      pct = v[i].pct;
      beats = 0; lasts = 0;
      push_exp(v[i].exp);
      do_start(v[i].lc);
      run(SD + 20 + v[i].exp * 60, dc, fr, fv);
      chk($sformatf("v%0d_done", i), done, 1);
      if (v[i].exp_done >= 0) chk($sformatf("v%0d_done_at", i), dc, v[i].exp_done);
      chk($sformatf("v%0d_any_valid", i), fv >= 0, v[i].exp > 0);
      chk($sformatf("v%0d_beats", i), beats, v[i].exp);
      chk($sformatf("v%0d_lasts", i), lasts, v[i].exp > 0);
      chk($sformatf("v%0d_sb_empty", i), sb.size(), 0);
    end

    pct = 100;
    beats = 0; lasts = 0;
    push_exp(6);
    do_start(6);
    for (int n = 0; n < SD + 40 && beats < 3; n++) @(negedge clk);
    chk("r6_reach_beat3", beats, 3);
    #2 rst_n = 1'b0;
    line_count = 6;
    #1 chk("r6_async_rst", {tvalid, tlast, rd_en, busy, done, core_rst}, 6'b000101);
    sb.delete();
    push_exp(6);
    repeat (2) @(negedge clk);
    beats = 0; lasts = 0;
    rst_n = 1'b1;
    run(SD + 40, dc, fr, fv);
    chk("r6_done_at", dc, SD + 9);
    chk("r6_beats", beats, 6);
    chk("r6_lasts", lasts, 1);
    chk("r6_sb_empty", sb.size(), 0);

    nb = 0; last_at = -1;
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int n = 0; n < SD + 40 && !done_b; n++) begin
      @(negedge clk);
      if (tvalid_b && tready_b) begin
        if (nb < 2) got[nb] = tdata_b;
        if (tlast_b) last_at = nb;
        nb++;
      end
    end
    chk("w64_done", done_b, 1);
    chk("w64_beats", nb, 2);
    chk("w64_last", last_at, 1);
    chk("w64_addr0", got[0][31:0], 32'hFFFF_FFF8);
    chk("w64_addr1", got[1][31:0], 32'h0000_0000);
    chk("w64_data0", got[0][95:32], {mem[0], ~mem[0]});
    chk("w64_data1", got[1][95:32], {mem[1], ~mem[1]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
